mul_op_frontend: RTL and testbench
==================================

// Module: mul_op_frontend
// PURPOSE
//  Front end for RV32 M-extension multiplies (MUL/MULH/MULHSU/MULHU) placed in front of the DSP-tiled
//  unsigned multiplier in the EX stage. Converts signed operands to magnitudes, issues a (XLEN+1)-bit
//  unsigned multiply, re-applies sign, selects low/high word, and returns the result with a
//  ready/valid handshake, flush support and an early-completion hint for the writeback scheduler.
// PARAMETERS
//  XLEN         32           architectural operand/result width
//  MUL_W        XLEN+1       width of each operand driven to the unsigned multiplier (localparam)
// PORTS
//  i_clk                  in   1         clock
//  i_rst                  in   1         synchronous, active-high reset
//  i_valid                in   1         request valid
//  o_ready                out  1         frontend idle; request accepted when i_valid&&o_ready&&!i_flush
//  i_op                   in   2         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
//  i_rs1, i_rs2           in   XLEN      operands
//  i_flush                in   1         kill in-flight op (pipeline redirect)
//  o_valid                out  1         one-cycle result pulse
//  o_result               out  XLEN      result, held until next o_valid
//  o_completing_next_cycle out 1         o_valid will pulse next cycle
//  o_mul_valid            out  1         one-cycle issue pulse to unsigned multiplier
//  o_mul_a, o_mul_b       out  MUL_W     zero-extended magnitudes
//  i_mul_product          in   2*MUL_W   unsigned product
//  i_mul_valid            in   1         product valid pulse
// BEHAVIOUR
//  - Reset: state IDLE; o_valid, o_mul_valid, o_completing_next_cycle 0; o_result, o_mul_a/b 0; o_ready 1.
//  - Sign rules: rs1 signed for MULH/MULHSU, rs2 signed for MULH only. Magnitude = two's negate if signed
//    and MSB set (INT_MIN -> 2^(XLEN-1), fits XLEN bits). neg_flag = sign1 ^ sign2, registered on accept.
//  - FSM IDLE -> WAIT -> FIX -> IDLE; DRAIN for flushed ops.
//    IDLE: on accept, register magnitudes/op/neg_flag; o_mul_valid=1 next cycle (single pulse); -> WAIT.
//    WAIT: on i_mul_valid, capture i_mul_product[2*XLEN-1:0] -> prod_reg; -> FIX.
//    FIX : o_completing_next_cycle=1 (combinational on state); register result = op==MUL ?
//          signed_prod[XLEN-1:0] : signed_prod[2*XLEN-1:XLEN], signed_prod = neg_flag ? -prod_reg : prod_reg;
//          o_valid=1 next cycle; -> IDLE (o_ready 1 in that same cycle; back-to-back issue allowed).
//  - Latency: o_valid exactly 2 cycles after the i_mul_valid cycle; o_mul_valid 1 cycle after accept.
//  - o_ready = (state==IDLE). i_valid while not ready ignored; upstream holds.
//  - Flush: IDLE: no accept. WAIT: -> DRAIN (or -> IDLE if i_mul_valid same cycle, product discarded).
//    DRAIN: o_ready 0; on i_mul_valid -> IDLE, product discarded. FIX: -> IDLE, no o_valid, no hint.
//    Flush on cycle of o_mul_valid pulse: still -> DRAIN (multiplier cannot be aborted).
//  - i_mul_valid outside WAIT/DRAIN ignored. Reset mid-operation: to IDLE; multiplier shares i_rst.
// CONFIGURATION
//  MUL_FUSE_CACHE_EN defined: one-entry cache {valid, rs1, rs2, sign1, sign2, signed_prod 2*XLEN}, written
//    on every non-flushed FIX. On accept, hit if rs1/rs2 match and (op==MUL or sign1/sign2 match);
//    hit skips multiplier: IDLE -> FIX directly (o_mul_valid stays 0), o_valid 2 cycles after accept.
//    Invalidated by reset only. Flush on a hit's FIX cycle suppresses o_valid as normal.
//  Undefined: no cache; every op issues to the multiplier.
// TESTING
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> o_mul_a/b=0x0FFFFFFFF, o_result=0xFFFFFFFE, o_valid 2 cyc after i_mul_valid.
//  MULH 0x80000000 x 0x80000000 -> magnitudes 0x080000000, result 0x40000000; MUL -1 x 5 -> 0xFFFFFFFB.
//  MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFF; hint high exactly 1 cycle before o_valid.
//  i_flush in WAIT, i_mul_valid 3 cycles later -> no o_valid, o_ready 0 until drain, next op correct.
//  Back-to-back MUL 3x7 then MULHU 2^31 x 4 -> 0x15 then 0x2; i_valid during busy ignored.
//  MUL_FUSE_CACHE_EN: MULH a,b then MUL a,b -> second op no o_mul_valid, o_valid 2 cycles after accept.

Source files
------------

// File: rtl/mul_op_frontend.sv
// mul_op_frontend: RV32 M-extension multiply front end (MUL/MULH/MULHSU/MULHU) for an unsigned multiplier
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_valid / o_ready        request handshake; accepted on i_valid && o_ready && !i_flush
//   i_op, i_rs1, i_rs2       funct3[1:0] (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU) and operands
//   i_flush                  kills the in-flight op (pipeline redirect)
//   o_valid, o_result        one-cycle result pulse; result held until the next pulse
//   o_completing_next_cycle  o_valid will pulse on the next cycle
//   o_mul_valid, o_mul_a/b   one-cycle issue pulse and zero-extended magnitudes to the multiplier
//   i_mul_valid, i_mul_product  product return from the multiplier
// Build option: define MUL_FUSE_CACHE_EN to add a one-entry product cache that bypasses the
// multiplier when the same operands (and compatible sign interpretation) repeat.
module mul_op_frontend #(
    parameter int XLEN = 32,
    localparam int MUL_W = XLEN + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_op,
    input  logic [XLEN-1:0]    i_rs1,
    input  logic [XLEN-1:0]    i_rs2,
    input  logic               i_flush,
    output logic               o_valid,
    output logic [XLEN-1:0]    o_result,
    output logic               o_completing_next_cycle,
    output logic               o_mul_valid,
    output logic [MUL_W-1:0]   o_mul_a,
    output logic [MUL_W-1:0]   o_mul_b,
    input  logic [2*MUL_W-1:0] i_mul_product,
    input  logic               i_mul_valid
);
    typedef enum logic [1:0] {IDLE, WAIT, FIX, DRAIN} state_t;

    state_t            state, state_n;
    logic              accept, hit, sign1, sign2, neg_q;
    logic [XLEN-1:0]   mag1, mag2;
    logic [1:0]        op_q;
    logic [2*XLEN-1:0] prod_q, signed_prod, hit_prod;
    logic              unused_prod_hi;

    // sign flags are "operand is interpreted as signed and is negative"
    assign sign1       = (i_op == 2'b01 || i_op == 2'b10) && i_rs1[XLEN-1];
    assign sign2       = (i_op == 2'b01) && i_rs2[XLEN-1];
    // INT_MIN negates to 2^(XLEN-1), which still fits unsigned in XLEN bits
    assign mag1        = sign1 ? -i_rs1 : i_rs1;
    assign mag2        = sign2 ? -i_rs2 : i_rs2;
    assign accept      = i_valid && state == IDLE && !i_flush;
    assign signed_prod = neg_q ? -prod_q : prod_q;
    // magnitudes are at most 2^XLEN-1, so the product never reaches the top bits
    assign unused_prod_hi = &{1'b0, i_mul_product[2*MUL_W-1:2*XLEN]};

`ifdef MUL_FUSE_CACHE_EN
    logic              c_valid, c_s1, c_s2, s1_q, s2_q;
    logic [XLEN-1:0]   c_rs1, c_rs2, rs1_q, rs2_q;
    logic [2*XLEN-1:0] c_prod;

    // MUL only uses the low word, which is identical for any sign interpretation
    assign hit = c_valid && i_rs1 == c_rs1 && i_rs2 == c_rs2 &&
                 (i_op == 2'b00 || (sign1 == c_s1 && sign2 == c_s2));
    assign hit_prod = c_prod;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            c_valid <= 1'b0;
            c_s1    <= 1'b0;
            c_s2    <= 1'b0;
            c_rs1   <= '0;
            c_rs2   <= '0;
            c_prod  <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            if (accept) begin
                rs1_q <= i_rs1;
                rs2_q <= i_rs2;
                // a hit replays the cached product, so keep the signs it was computed with
                s1_q  <= hit ? c_s1 : sign1;
                s2_q  <= hit ? c_s2 : sign2;
            end
            if (state == FIX && !i_flush) begin
                c_valid <= 1'b1;
                c_rs1   <= rs1_q;
                c_rs2   <= rs2_q;
                c_s1    <= s1_q;
                c_s2    <= s2_q;
                c_prod  <= signed_prod;
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_prod = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n                 = state;
        o_ready                 = 1'b0;
        o_completing_next_cycle = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (accept) state_n = hit ? FIX : WAIT;
            end
            WAIT: begin
                // a flushed op still has a product coming unless it arrives right now
                if (i_mul_valid) state_n = i_flush ? IDLE : FIX;
                else if (i_flush) state_n = DRAIN;
            end
            FIX: begin
                o_completing_next_cycle = !i_flush;
                state_n                 = IDLE;
            end
            DRAIN: begin
                if (i_mul_valid) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_result    <= '0;
            o_mul_valid <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
            op_q        <= 2'b00;
            neg_q       <= 1'b0;
            prod_q      <= '0;
        end else begin
            o_mul_valid <= accept && !hit;
            o_valid     <= state == FIX && !i_flush;
            if (accept) begin
                o_mul_a <= {1'b0, mag1};
                o_mul_b <= {1'b0, mag2};
                op_q    <= i_op;
                neg_q   <= hit ? 1'b0 : sign1 ^ sign2;
            end
            if (accept && hit)
                prod_q <= hit_prod;
            else if (state == WAIT && i_mul_valid && !i_flush)
                prod_q <= i_mul_product[2*XLEN-1:0];
            if (state == FIX && !i_flush)
                o_result <= (op_q == 2'b00) ? signed_prod[XLEN-1:0] : signed_prod[2*XLEN-1:XLEN];
        end
    end
endmodule

// File: tb/tb_mul_op_frontend.sv
// tb_mul_op_frontend: randomized self-checking bench for mul_op_frontend with a behavioural multiply model
module tb_mul_op_frontend;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic [31:0] result;
    logic        done_next;
    logic        mul_valid;
    logic [32:0] mul_a;
    logic [32:0] mul_b;
    logic [65:0] product = '0;
    logic        prod_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result = '0;

    bit          mc_valid = 0;
    logic [31:0] mc_a, mc_b;
    bit          mc_n1, mc_n2;

    mul_op_frontend dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_op(op_i),
        .i_rs1(rs1), .i_rs2(rs2), .i_flush(flush), .o_valid(res_valid), .o_result(result),
        .o_completing_next_cycle(done_next), .o_mul_valid(mul_valid), .o_mul_a(mul_a), .o_mul_b(mul_b),
        .i_mul_product(product), .i_mul_valid(prod_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [127:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b10) ? {{96{a[31]}}, a} : {96'd0, a};
        eb = (op == 2'b01) ? {{96{b[31]}}, b} : {96'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit noise);
        logic [31:0] exp_r;
        logic [32:0] exp_a, exp_b;
        longint      la, lb;
        bit          exp_hit;
        exp_r = ref_mul(op, a, b);
        la = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'(a);
        lb = (op == 2'b01) ? longint'($signed(b)) : longint'(b);
        exp_a = 33'(la < 0 ? -la : la);
        exp_b = 33'(lb < 0 ? -lb : lb);
        exp_hit = 0;
`ifdef MUL_FUSE_CACHE_EN
        exp_hit = mc_valid && a == mc_a && b == mc_b && (op == 2'b00 || ((la < 0) == mc_n1 && (lb < 0) == mc_n2));
`endif
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_before_issue: got %b expected 1", ready); end
        valid = 1'b1; op_i = op; rs1 = a; rs2 = b;
        step();
        valid = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL valid_single_pulse: got %b expected 0", res_valid); end
        checks++;
        if (mul_valid !== !exp_hit) begin errors++; $display("FAIL issue_pulse op=%0d: got %b expected %b", op, mul_valid, !exp_hit); end
        if (!exp_hit) begin
            checks++;
            if (mul_a !== exp_a) begin errors++; $display("FAIL mul_a op=%0d a=%h: got %h expected %h", op, a, mul_a, exp_a); end
            checks++;
            if (mul_b !== exp_b) begin errors++; $display("FAIL mul_b op=%0d b=%h: got %h expected %h", op, b, mul_b, exp_b); end
            for (int i = 0; i < lat; i++) begin
                if (noise) begin valid = 1'b1; rs1 = $urandom; rs2 = $urandom; op_i = 2'($urandom_range(0, 3)); end
                step();
                checks++;
                if (mul_valid !== 1'b0 || ready !== 1'b0) begin
                    errors++; $display("FAIL busy_wait: mul_valid=%b ready=%b expected 0 0", mul_valid, ready);
                end
            end
            valid = 1'b0; op_i = op; rs1 = a; rs2 = b;
            prod_valid = 1'b1;
            product = 66'(mul_a) * 66'(mul_b);
            step();
            prod_valid = 1'b0;
        end
        checks++;
        if (done_next !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL done_next_before_valid: done_next=%b valid=%b expected 1 0", done_next, res_valid);
        end
        step();
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL result_valid op=%0d: got %b expected 1", op, res_valid); end
        checks++;
        if (result !== exp_r) begin errors++; $display("FAIL result op=%0d a=%h b=%h: got %h expected %h", op, a, b, result, exp_r); end
        checks++;
        if (done_next !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL after_result: done_next=%b ready=%b expected 0 1", done_next, ready);
        end
        last_result = exp_r;
        if (!exp_hit) begin
            mc_valid = 1; mc_a = a; mc_b = b; mc_n1 = la < 0; mc_n2 = lb < 0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || res_valid !== 1'b0 || mul_valid !== 1'b0 || done_next !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: ready=%b valid=%b mul_valid=%b done_next=%b expected 1 0 0 0", ready, res_valid, mul_valid, done_next);
        end
        checks++;
        if (result !== 32'd0 || mul_a !== 33'd0 || mul_b !== 33'd0) begin
            errors++; $display("FAIL reset_data: result=%h a=%h b=%h expected 0 0 0", result, mul_a, mul_b);
        end
    endtask

    task automatic test_directed;
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'd5, 0, 0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        run_op(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 2, 0);
    endtask

    task automatic test_back_to_back;
        run_op(2'b00, 32'd3, 32'd7, 2, 1);
        run_op(2'b11, 32'h8000_0000, 32'd4, 0, 1);
    endtask

    task automatic test_flush;
        // flush in WAIT, product arrives 3 cycles later while draining
        valid = 1'b1; op_i = 2'b11; rs1 = 32'h1357_9BDF; rs2 = 32'h2468_ACE0;
        step();
        valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ready !== 1'b0 || res_valid !== 1'b0) begin
                errors++; $display("FAIL drain_busy: ready=%b valid=%b expected 0 0", ready, res_valid);
            end
            step();
        end
        prod_valid = 1'b1; product = 66'h1234;
        step();
        prod_valid = 1'b0;
        checks++;
        if (ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL drain_done: ready=%b valid=%b expected 1 0", ready, res_valid);
        end
        step();
        checks++;
        if (res_valid !== 1'b0 || done_next !== 1'b0) begin
            errors++; $display("FAIL drain_no_result: valid=%b done_next=%b expected 0 0", res_valid, done_next);
        end
        run_op(2'b01, 32'hFFFF_FFF0, 32'd16, 1, 0);
        // flush on the issue pulse cycle still drains
        valid = 1'b1; op_i = 2'b00; rs1 = 32'h0BAD_F00D; rs2 = 32'd9;
        step();
        valid = 1'b0; flush = 1'b1;
        checks++;
        if (mul_valid !== 1'b1) begin errors++; $display("FAIL flush_issue_pulse: got %b expected 1", mul_valid); end
        step();
        flush = 1'b0;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL flush_on_issue_drain: ready got %b expected 0", ready); end
        prod_valid = 1'b1;
        step();
        prod_valid = 1'b0;
        checks++;
        if (ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL flush_on_issue_done: ready=%b valid=%b expected 1 0", ready, res_valid);
        end
        // flush with the product arriving in the same WAIT cycle goes straight to idle
        valid = 1'b1; op_i = 2'b10; rs1 = 32'hCAFE_0001; rs2 = 32'd77;
        step();
        valid = 1'b0; flush = 1'b1; prod_valid = 1'b1;
        step();
        flush = 1'b0; prod_valid = 1'b0;
        checks++;
        if (ready !== 1'b1 || done_next !== 1'b0) begin
            errors++; $display("FAIL flush_with_product: ready=%b done_next=%b expected 1 0", ready, done_next);
        end
        step();
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_with_product_valid: got %b expected 0", res_valid); end
        // flush in FIX drops the result and the early-completion flag, previous result is held
        valid = 1'b1; op_i = 2'b00; rs1 = 32'h0F0F_0F0F; rs2 = 32'd3;
        step();
        valid = 1'b0; prod_valid = 1'b1; product = 66'(mul_a) * 66'(mul_b);
        step();
        prod_valid = 1'b0; flush = 1'b1;
        #1;
        checks++;
        if (done_next !== 1'b0) begin errors++; $display("FAIL flush_fix_done_next: got %b expected 0", done_next); end
        step();
        flush = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL flush_fix: valid=%b ready=%b expected 0 1", res_valid, ready);
        end
        checks++;
        if (result !== last_result) begin errors++; $display("FAIL result_held: got %h expected %h", result, last_result); end
        run_op(2'b00, 32'h0F0F_0F0F, 32'd5, 0, 0);
    endtask

    task automatic test_random;
        logic [31:0] corner [6];
        logic [31:0] a, b;
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            run_op(2'($urandom_range(0, 3)), a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef MUL_FUSE_CACHE_EN
    task automatic test_cache;
        run_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 2, 0);
        run_op(2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 2, 0);
        run_op(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 1, 0);
        run_op(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 1, 0);
        run_op(2'b10, 32'h0000_1111, 32'h8888_0000, 1, 0);
        run_op(2'b11, 32'h0000_1111, 32'h8888_0000, 1, 0);
    endtask
`endif

    task automatic test_reset_mid;
        valid = 1'b1; op_i = 2'b01; rs1 = 32'h5555_AAAA; rs2 = 32'h3333_CCCC;
        step();
        valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || mul_valid !== 1'b0 || res_valid !== 1'b0 || result !== 32'd0) begin
            errors++; $display("FAIL reset_mid: ready=%b mul_valid=%b valid=%b result=%h expected 1 0 0 0", ready, mul_valid, res_valid, result);
        end
        mc_valid = 0;
        last_result = '0;
        step();
        run_op(2'b01, 32'h5555_AAAA, 32'h3333_CCCC, 1, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
`ifdef MUL_FUSE_CACHE_EN
        test_cache();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
